// File: rtl/filter_step_sequencer.sv
// Step-response sequencer: holds a filter in reset, then walks a programmed table of
// input levels, timing how long v_out takes to settle near each step's target.
module filter_step_sequencer #(
  parameter int WIDTH      = 18,
  parameter int NUM_STEPS  = 4,
  parameter int IDX_W      = $clog2(NUM_STEPS),
  parameter int TOL        = 16,
  parameter int SETTLE_CNT = 4,
  parameter int TIMEOUT    = 1000,
  parameter int CNT_W      = $clog2(TIMEOUT + 1),
  parameter int RST_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_we,
  input  logic [IDX_W-1:0]        cfg_addr,
  input  logic signed [WIDTH-1:0] cfg_level,
  input  logic signed [WIDTH-1:0] cfg_target,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] v_in,
  output logic                    filt_rst,
  input  logic signed [WIDTH-1:0] v_out,
  output logic                    res_valid,
  output logic [IDX_W-1:0]        res_step,
  output logic [CNT_W-1:0]        res_cycles,
  output logic                    res_timeout
);

  localparam int IB_W = $clog2(SETTLE_CNT + 1);
  localparam int RC_W = $clog2(RST_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, FRST, RUN, DONE} state_t;

  state_t state, state_nx;

  logic signed [WIDTH-1:0] lvl_tab [NUM_STEPS];
  logic signed [WIDTH-1:0] tgt_tab [NUM_STEPS];

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [IB_W-1:0]  ib;
  logic [RC_W-1:0]  rcnt;

  logic signed [WIDTH:0] err_p0;
  logic                  in_band_p0;
  logic                  settle_p0;
  logic                  tmo_p0;
  logic                  step_end_p0;
  logic                  last_p0;

  // Magnitude of a WIDTH+1 error; the most negative value maps to 2^WIDTH unsigned.
  function automatic logic [WIDTH:0] abs_err(input logic signed [WIDTH:0] e);
    return e[WIDTH] ? (~e + 1'b1) : e;
  endfunction

  // Stage p0: band test on the live filter output
  assign err_p0      = {v_out[WIDTH-1], v_out} - {tgt_tab[idx][WIDTH-1], tgt_tab[idx]};
  assign in_band_p0  = abs_err(err_p0) <= (WIDTH+1)'(TOL);
  assign settle_p0   = (state == RUN) && in_band_p0 && (ib == IB_W'(SETTLE_CNT - 1));
  assign tmo_p0      = (state == RUN) && (cnt == CNT_W'(TIMEOUT));
  assign step_end_p0 = settle_p0 || tmo_p0;
  assign last_p0     = (idx == IDX_W'(NUM_STEPS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b1;
    done     = 1'b0;
    filt_rst = 1'b0;
    v_in     = lvl_tab[idx];
    case (state)
      IDLE: begin
        busy     = 1'b0;
        filt_rst = 1'b1;
        v_in     = '0;
        if (start) state_nx = FRST;
      end
      FRST: begin
        filt_rst = 1'b1;
        if (rcnt == RC_W'(RST_CYCLES - 1)) state_nx = RUN;
      end
      RUN: begin
        if (step_end_p0 && last_p0) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        lvl_tab[i] <= '0;
        tgt_tab[i] <= '0;
      end
    end else if (cfg_we && (state == IDLE)) begin
      lvl_tab[cfg_addr] <= cfg_level;
      tgt_tab[cfg_addr] <= cfg_target;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx  <= '0;
      cnt  <= '0;
      ib   <= '0;
      rcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx  <= '0;
            rcnt <= '0;
          end
        end
        FRST: begin
          rcnt <= rcnt + RC_W'(1);
          cnt  <= CNT_W'(1);
          ib   <= '0;
        end
        RUN: begin
          if (step_end_p0) begin
            // The filter keeps running across steps; only the step bookkeeping restarts.
            if (!last_p0) idx <= idx + IDX_W'(1);
            cnt <= CNT_W'(1);
            ib  <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            ib  <= in_band_p0 ? ib + IB_W'(1) : '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p1: registered per-step result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid   <= 1'b0;
      res_step    <= '0;
      res_cycles  <= '0;
      res_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (step_end_p0) begin
        res_valid   <= 1'b1;
        res_step    <= idx;
        res_timeout <= !settle_p0;
        res_cycles  <= settle_p0 ? cnt - CNT_W'(SETTLE_CNT - 1) : CNT_W'(TIMEOUT);
      end
    end
  end

endmodule

// File: tb/tb_filter_step_sequencer.sv
// Bench for filter_step_sequencer: scripted and filter-driven step tables checked
// against a timeline model built from the settle/timeout rules.
module tb_filter_step_sequencer;

  localparam int W     = 18;
  localparam int N     = 4;
  localparam int IW    = 2;
  localparam int TOL   = 16;
  localparam int S     = 4;
  localparam int TO    = 100;
  localparam int CW    = 7;
  localparam int RC    = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic                cfg_we;
  logic [IW-1:0]       cfg_addr;
  logic signed [W-1:0] cfg_level;
  logic signed [W-1:0] cfg_target;
  logic                start;
  logic                busy;
  logic                done;
  logic signed [W-1:0] v_in;
  logic                filt_rst;
  logic signed [W-1:0] v_out;
  logic                res_valid;
  logic [IW-1:0]       res_step;
  logic [CW-1:0]       res_cycles;
  logic                res_timeout;

  logic signed [W-1:0] drv;
  logic                use_filt;
  int                  fy;

  int n_tests = 0;
  int n_fail  = 0;

  int lvl   [N];
  int tgt   [N];
  int scr   [N][TO];
  int e_end [N];
  int e_cyc [N];
  int e_to  [N];

  filter_step_sequencer #(
    .WIDTH(W), .NUM_STEPS(N), .IDX_W(IW), .TOL(TOL), .SETTLE_CNT(S),
    .TIMEOUT(TO), .CNT_W(CW), .RST_CYCLES(RC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_level(cfg_level), .cfg_target(cfg_target), .start(start),
    .busy(busy), .done(done), .v_in(v_in), .filt_rst(filt_rst),
    .v_out(v_out), .res_valid(res_valid), .res_step(res_step),
    .res_cycles(res_cycles), .res_timeout(res_timeout)
  );

  always #5 clk = ~clk;

  // First-order filter y += (x - y) >> 3, driven by the DUT's own v_in/filt_rst.
  always @(posedge clk) begin
    if (filt_rst) fy <= 0;
    else          fy <= fy + ((int'(v_in) - fy) >>> 3);
  end

  assign v_out = use_filt ? W'(fy) : drv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit inb(input int v, input int t);
    return ((v - t) <= TOL) && ((t - v) <= TOL);
  endfunction

  // A step ends at the first cycle whose trailing S samples are all in band, else at TO.
  task automatic eval_step(input int k);
    bit found;
    found    = 1'b0;
    e_end[k] = TO;
    e_cyc[k] = TO;
    e_to[k]  = 1;
    for (int c = S; c <= TO && !found; c++) begin
      bit ok;
      ok = 1'b1;
      for (int j = c - S + 1; j <= c; j++)
        if (!inb(scr[k][j-1], tgt[k])) ok = 1'b0;
      if (ok) begin
        found    = 1'b1;
        e_end[k] = c;
        e_cyc[k] = c - S + 1;
        e_to[k]  = 0;
      end
    end
  endtask

  task automatic eval_all();
    for (int k = 0; k < N; k++) eval_step(k);
  endtask

  task automatic set_const(input int k, input int v);
    for (int c = 0; c < TO; c++) scr[k][c] = v;
  endtask

  function automatic int rnd_v(input int t, input int pct);
    int off;
    if (int'($urandom_range(0, 99)) < pct)
      return t + int'($urandom_range(0, 2 * TOL)) - TOL;
    off = TOL + 1 + int'($urandom_range(0, 40));
    return ($urandom_range(0, 1) == 1) ? t + off : t - off;
  endfunction

  task automatic set_random(input int k);
    int pct;
    pct = int'($urandom_range(40, 95));
    for (int c = 0; c < TO; c++) scr[k][c] = rnd_v(tgt[k], pct);
  endtask

  // Expected filter trajectory with level k applied for exactly the cycles step k lasts.
  task automatic fill_filter();
    int y, yl;
    y = 0;
    for (int k = 0; k < N; k++) begin
      int yy;
      yy = y;
      for (int c = 0; c < TO; c++) begin
        scr[k][c] = yy;
        yy = yy + ((lvl[k] - yy) >>> 3);
      end
      eval_step(k);
      yl = scr[k][e_end[k]-1];
      y  = yl + ((lvl[k] - yl) >>> 3);
    end
  endtask

  task automatic cfg_write(input int a, input int l, input int t);
    cfg_we     = 1'b1;
    cfg_addr   = IW'(a);
    cfg_level  = W'(l);
    cfg_target = W'(t);
    tick();
    cfg_we     = 1'b0;
  endtask

  task automatic program_table();
    for (int k = 0; k < N; k++) cfg_write(k, lvl[k], tgt[k]);
  endtask

  task automatic run_seq(input bit inject, input int abort_k);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("frst1_busy", int'(busy), 1);
    chk("frst1_filt_rst", int'(filt_rst), 1);
    chk("frst1_v_in", int'(v_in), lvl[0]);
    chk("frst1_done", int'(done), 0);
    tick();
    chk("frst2_filt_rst", int'(filt_rst), 1);
    chk("frst2_busy", int'(busy), 1);
    tick();
    for (int k = 0; k < N; k++) begin
      for (int c = 1; c <= e_end[k]; c++) begin
        if (k == abort_k && c == 2) begin
          rst = 1'b0;
          #1;
          chk("abort_v_in", int'(v_in), 0);
          chk("abort_filt_rst", int'(filt_rst), 1);
          chk("abort_busy", int'(busy), 0);
          chk("abort_res_valid", int'(res_valid), 0);
          chk("abort_res_step", int'(res_step), 0);
          chk("abort_res_cycles", int'(res_cycles), 0);
          tick();
          rst = 1'b1;
          for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_abort_res_valid", int'(res_valid), 0);
            chk("post_abort_done", int'(done), 0);
            chk("post_abort_busy", int'(busy), 0);
          end
          return;
        end
        chk("run_filt_rst", int'(filt_rst), 0);
        chk("run_v_in", int'(v_in), lvl[k]);
        chk("run_busy", int'(busy), 1);
        chk("run_done", int'(done), 0);
        if (c == 1 && k > 0) begin
          chk("res_valid", int'(res_valid), 1);
          chk("res_step", int'(res_step), k - 1);
          chk("res_cycles", int'(res_cycles), e_cyc[k-1]);
          chk("res_timeout", int'(res_timeout), e_to[k-1]);
        end else begin
          chk("res_valid_idle", int'(res_valid), 0);
        end
        if (inject && k == 1 && c == 3) begin
          cfg_we     = 1'b1;
          cfg_addr   = '0;
          cfg_level  = W'(12345);
          cfg_target = W'(-12345);
          start      = 1'b1;
        end
        drv = W'(scr[k][c-1]);
        tick();
        cfg_we = 1'b0;
        start  = 1'b0;
      end
    end
    chk("done_pulse", int'(done), 1);
    chk("done_busy", int'(busy), 1);
    chk("done_filt_rst", int'(filt_rst), 0);
    chk("done_v_in", int'(v_in), lvl[N-1]);
    chk("last_res_valid", int'(res_valid), 1);
    chk("last_res_step", int'(res_step), N - 1);
    chk("last_res_cycles", int'(res_cycles), e_cyc[N-1]);
    chk("last_res_timeout", int'(res_timeout), e_to[N-1]);
    tick();
    chk("idle_done", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_filt_rst", int'(filt_rst), 1);
    chk("idle_v_in", int'(v_in), 0);
    chk("idle_res_valid", int'(res_valid), 0);
    chk("hold_res_step", int'(res_step), N - 1);
    chk("hold_res_cycles", int'(res_cycles), e_cyc[N-1]);
  endtask

  initial begin
    rst        = 1'b0;
    cfg_we     = 1'b0;
    cfg_addr   = '0;
    cfg_level  = '0;
    cfg_target = '0;
    start      = 1'b0;
    drv        = '0;
    use_filt   = 1'b0;
    tick();
    tick();
    chk("rst_v_in", int'(v_in), 0);
    chk("rst_filt_rst", int'(filt_rst), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_step", int'(res_step), 0);
    chk("rst_res_cycles", int'(res_cycles), 0);
    chk("rst_res_timeout", int'(res_timeout), 0);
    rst = 1'b1;
    tick();

    // Immediate settle, tolerance edge 16/17, and flicker on cycle 4
    lvl = '{500, 0, 0, 1000};
    tgt = '{500, 0, 0, 1000};
    set_const(0, 500);
    set_const(1, 16);
    set_const(2, 17);
    set_const(3, 1000);
    scr[3][3] = 0;
    eval_all();
    program_table();
    run_seq(1'b0, -1);

    // Timeout, negative tolerance edge, full-range error, random flicker
    lvl = '{1000, -300, 77, -5};
    tgt = '{1000, -300, -131072, int'($urandom_range(0, 2000)) - 1000};
    set_const(0, 0);
    set_const(1, -316);
    set_const(2, 131071);
    set_random(3);
    eval_all();
    program_table();
    run_seq(1'b0, -1);

    // Real filter response; busy-time cfg_we/start must not disturb the table
    lvl = '{1000, -1000, 0, 500};
    tgt = '{1000, -1000, 0, 500};
    use_filt = 1'b1;
    fill_filter();
    program_table();
    run_seq(1'b1, -1);
    run_seq(1'b0, -1);
    use_filt = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) begin
        lvl[k] = int'($urandom_range(0, 20000)) - 10000;
        tgt[k] = int'($urandom_range(0, 200000)) - 100000;
        set_random(k);
      end
      eval_all();
      program_table();
      run_seq(1'b0, -1);
    end

    // Abort mid-step 1; the cleared table then drives zero levels
    run_seq(1'b0, 1);
    lvl = '{0, 0, 0, 0};
    tgt = '{0, 0, 0, 0};
    for (int k = 0; k < N; k++) set_const(k, 0);
    eval_all();
    run_seq(1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
